// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: data-memory access FSM with timeout and registered writeback
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dest_reg_value_ixmem_p1,
    input  logic [2:0]  dest_reg_index_ixmem_p1,
    input  logic        dest_reg_write_valid_ixmem_p1,
    input  logic [15:0] mem_addr_ixmem_p1,
    input  logic        ldst_valid_ixmem_p1,
    input  logic [1:0]  store_valid_ixmem_p1,
    input  logic [15:0] mem_data_in_ixmem_p1,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [15:0] dmem_req_addr,
    output logic [15:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [15:0] dmem_rsp_rdata,
    output logic        mem_stall_p1,
    output logic [2:0]  dest_reg_index_memwb_p1,
    output logic [15:0] dest_reg_value_memwb_p1,
    output logic        dest_reg_write_valid_memwb_p1,
    output logic        mem_err_memwb_p1
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   val_q;
    logic [2:0]    idx_q;
    logic          wv_q;
    logic          we_q;
    logic [2:0]    wb_idx_q;
    logic [15:0]   wb_val_q;
    logic          wb_wv_q;
    logic          err_q;

    logic launch;
    logic unaligned;
    logic req_fire;
    logic rsp_fire;
    logic store_done;
    logic timeout;

    always_comb begin
        launch     = (state_q == S_IDLE) && ldst_valid_ixmem_p1 && !mem_addr_ixmem_p1[0];
        unaligned  = (state_q == S_IDLE) && ldst_valid_ixmem_p1 && mem_addr_ixmem_p1[0];
        req_fire   = (state_q == S_REQ) && dmem_req_ready;
        rsp_fire   = (state_q == S_RESP) && dmem_rsp_valid;
        store_done = req_fire && we_q;
        // a completion landing on the last counted cycle takes priority over the abort
        timeout    = (state_q != S_IDLE) && !store_done && !rsp_fire && (cnt_q == CNT_LAST);
    end

    always_comb begin
        mem_stall_p1 = 1'b0;
        case (state_q)
            S_IDLE:  mem_stall_p1 = launch && !rst;
            S_REQ:   mem_stall_p1 = !store_done && !timeout;
            S_RESP:  mem_stall_p1 = !rsp_fire && !timeout;
            default: mem_stall_p1 = 1'b0;
        endcase
    end

    assign dmem_req_valid = (state_q == S_REQ);
    assign dmem_req_we    = we_q;
    assign dmem_req_addr  = {addr_q[15:1], 1'b0};
    assign dmem_req_wdata = wdata_q;

    assign dest_reg_index_memwb_p1       = wb_idx_q;
    assign dest_reg_value_memwb_p1       = wb_val_q;
    assign dest_reg_write_valid_memwb_p1 = wb_wv_q;
    assign mem_err_memwb_p1              = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            val_q    <= '0;
            idx_q    <= '0;
            wv_q     <= 1'b0;
            we_q     <= 1'b0;
            wb_idx_q <= '0;
            wb_val_q <= '0;
            wb_wv_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    err_q <= unaligned;
                    if (launch) begin
                        addr_q  <= mem_addr_ixmem_p1;
                        wdata_q <= mem_data_in_ixmem_p1;
                        val_q   <= dest_reg_value_ixmem_p1;
                        idx_q   <= dest_reg_index_ixmem_p1;
                        wv_q    <= dest_reg_write_valid_ixmem_p1;
                        we_q    <= |store_valid_ixmem_p1;
                        cnt_q   <= '0;
                        wb_wv_q <= 1'b0;
                        state_q <= S_REQ;
                    end else begin
                        wb_idx_q <= dest_reg_index_ixmem_p1;
                        wb_val_q <= dest_reg_value_ixmem_p1;
                        wb_wv_q  <= dest_reg_write_valid_ixmem_p1 && !ldst_valid_ixmem_p1;
                    end
                end
                S_REQ, S_RESP: begin
                    err_q   <= 1'b0;
                    wb_wv_q <= 1'b0;
                    if (store_done || rsp_fire) begin
                        wb_idx_q <= idx_q;
                        wb_val_q <= rsp_fire ? dmem_rsp_rdata : val_q;
                        wb_wv_q  <= wv_q;
                        state_q  <= S_IDLE;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (req_fire) begin
                            state_q <= S_RESP;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a transaction-level reference model
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] val_i = '0;
    logic [2:0]  idx_i = '0;
    logic        wv_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic        ldst_i = 1'b0;
    logic [1:0]  sv_i = '0;
    logic [15:0] wdata_i = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_rdata = '0;
    logic        stall;
    logic [2:0]  wb_idx;
    logic [15:0] wb_val;
    logic        wb_wv;
    logic        err;

    int errors = 0;
    int checks = 0;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .dest_reg_value_ixmem_p1       (val_i),
        .dest_reg_index_ixmem_p1       (idx_i),
        .dest_reg_write_valid_ixmem_p1 (wv_i),
        .mem_addr_ixmem_p1             (addr_i),
        .ldst_valid_ixmem_p1           (ldst_i),
        .store_valid_ixmem_p1          (sv_i),
        .mem_data_in_ixmem_p1          (wdata_i),
        .dmem_req_valid                (req_valid),
        .dmem_req_ready                (req_ready),
        .dmem_req_we                   (req_we),
        .dmem_req_addr                 (req_addr),
        .dmem_req_wdata                (req_wdata),
        .dmem_rsp_valid                (rsp_valid),
        .dmem_rsp_rdata                (rsp_rdata),
        .mem_stall_p1                  (stall),
        .dest_reg_index_memwb_p1       (wb_idx),
        .dest_reg_value_memwb_p1       (wb_val),
        .dest_reg_write_valid_memwb_p1 (wb_wv),
        .mem_err_memwb_p1              (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one ixmem bundle, plays the memory side with the given ready/response delays,
    // and compares against the outcome predicted from the stage's rules.
    task automatic run_op(input string tag, input logic ldst, input logic [1:0] sv,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [2:0] idx, input logic [15:0] val, input logic wv,
                          input int dr, input int rdly, input logic [15:0] rdata);
        bit is_st = (sv != 2'b00);
        int c;
        int exp_stall = 0, exp_reqc = 0, exp_hs = 0;
        logic exp_err = 1'b0, exp_wv = 1'b0, exp_done = 1'b0;
        logic [15:0] exp_val = val;
        int stc = 0, rqc = 0, hsc = 0, cyc = 0, seen = 0, rw = 0;
        bit in_resp = 0, done = 0, addr_bad = 0, err_bad = 0;

        if (!ldst) begin
            exp_done = 1'b1;
            exp_wv   = wv;
        end else if (addr[0]) begin
            exp_err = 1'b1;
        end else begin
            c = is_st ? dr : dr + 1 + rdly;
            if (c <= T - 1) begin
                exp_stall = 1 + c;
                exp_reqc  = dr + 1;
                exp_hs    = 1;
                exp_done  = 1'b1;
                exp_wv    = wv;
                exp_val   = is_st ? val : rdata;
            end else begin
                exp_stall = T;
                exp_reqc  = (dr <= T - 1) ? dr + 1 : T;
                exp_hs    = (dr <= T - 1) ? 1 : 0;
                exp_err   = 1'b1;
            end
        end

        ldst_i = ldst; sv_i = sv; addr_i = addr; wdata_i = wdata;
        idx_i = idx; val_i = val; wv_i = wv;
        while (!done && cyc < 40) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = 16'($urandom);
            #1;
            if (req_valid) begin
                rqc++;
                if (req_addr !== addr || req_wdata !== wdata || req_we !== is_st) addr_bad = 1;
                if (seen == dr) begin
                    req_ready = 1'b1;
                    hsc++;
                    if (!is_st) in_resp = 1;
                end else if (!is_st) begin
                    rsp_valid = 1'($urandom);
                end
                seen++;
            end else if (in_resp) begin
                if (rw == rdly) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = rdata;
                end
                rw++;
            end
            #1;
            if (cyc > 0 && err !== 1'b0) err_bad = 1;
            if (stall) stc++;
            else done = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        chk({tag, " stall_cycles"}, stc, exp_stall);
        chk({tag, " req_valid_cycles"}, rqc, exp_reqc);
        chk({tag, " handshakes"}, hsc, exp_hs);
        chk({tag, " req_fields_stable"}, addr_bad, 0);
        chk({tag, " err_quiet_midop"}, err_bad, 0);
        chk({tag, " err"}, err, exp_err);
        chk({tag, " wv"}, wb_wv, exp_wv);
        chk({tag, " req_valid_after"}, req_valid, 0);
        if (exp_done) begin
            chk({tag, " idx"}, wb_idx, idx);
            chk({tag, " val"}, wb_val, exp_val);
        end
    endtask

    initial begin
        #2;
        chk("reset req_valid", req_valid, 0);
        chk("reset stall", stall, 0);
        chk("reset wv", wb_wv, 0);
        chk("reset idx", wb_idx, 0);
        chk("reset val", wb_val, 0);
        chk("reset err", err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("nonmem",      1'b0, 2'b00, 16'h0000, 16'h0000, 3'd3, 16'h1234, 1'b1, 0, 0, 16'h0);
        run_op("ld_beef",     1'b1, 2'b00, 16'h0040, 16'h0000, 3'd5, 16'h0040, 1'b1, 0, 2, 16'hBEEF);
        run_op("stu_delay3",  1'b1, 2'b11, 16'h0102, 16'h00AA, 3'd2, 16'h0102, 1'b1, 3, 0, 16'h0);
        run_op("st_nowb",     1'b1, 2'b01, 16'h0200, 16'h5A5A, 3'd6, 16'h0200, 1'b0, 1, 0, 16'h0);
        run_op("st_10",       1'b1, 2'b10, 16'h0210, 16'h7777, 3'd1, 16'h0210, 1'b0, 0, 0, 16'h0);
        run_op("ld_unalign",  1'b1, 2'b00, 16'h0013, 16'h0000, 3'd4, 16'h0013, 1'b1, 0, 0, 16'h0);
        run_op("st_timeout",  1'b1, 2'b01, 16'h0300, 16'h1111, 3'd7, 16'h0300, 1'b0, 99, 0, 16'h0);
        run_op("nonmem_post", 1'b0, 2'b00, 16'h0000, 16'h0000, 3'd1, 16'hCAFE, 1'b1, 0, 0, 16'h0);
        run_op("ld_rsp_to",   1'b1, 2'b00, 16'h0400, 16'h0000, 3'd2, 16'h0400, 1'b1, 1, 99, 16'h0);
        run_op("ld_tie",      1'b1, 2'b00, 16'h0402, 16'h0000, 3'd3, 16'h0402, 1'b1, 1, 1, 16'h4242);

        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 4));
            logic [15:0] a = 16'($urandom) & 16'hFFFE;
            logic [2:0]  ix = 3'($urandom);
            logic [15:0] v = 16'($urandom);
            logic [15:0] wd = 16'($urandom);
            logic [15:0] rd = 16'($urandom);
            logic        w = 1'($urandom);
            case (kind)
                0: run_op("rnd_nonmem", 1'b0, 2'($urandom), a, wd, ix, v, w, 0, 0, rd);
                1: run_op("rnd_unalign", 1'b1, 2'($urandom), a | 16'h0001, wd, ix, v, w, 0, 0, rd);
                2: run_op("rnd_ld", 1'b1, 2'b00, a, wd, ix, v, w,
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rd);
                3: run_op("rnd_st", 1'b1, 2'b01, a, wd, ix, v, w, int'($urandom_range(0, 4)), 0, rd);
                default: run_op("rnd_stu", 1'b1, 2'b11, a, wd, ix, v, w, int'($urandom_range(0, 4)), 0, rd);
            endcase
        end

        ldst_i = 1'b1; sv_i = 2'b00; addr_i = 16'h0080; idx_i = 3'd6; val_i = 16'h0080; wv_i = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        #1;
        chk("rst_pre stall_in_resp", stall, 1);
        rst = 1'b1;
        #1;
        chk("rst_async req_valid", req_valid, 0);
        chk("rst_async stall", stall, 0);
        chk("rst_async wv", wb_wv, 0);
        chk("rst_async err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ldst_i = 1'b0; wv_i = 1'b0; val_i = 16'h1111; idx_i = 3'd2;
        rsp_valid = 1'b1;
        rsp_rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        chk("rst_after wv", wb_wv, 0);
        chk("rst_after err", err, 0);
        chk("rst_after val", wb_val, 16'h1111);
        chk("rst_after req_valid", req_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Receives the execute stage's ixmem bundle: ALU result, destination register, load/store controls and store data.
- Performs the data-memory access over a valid/ready request and response interface.
- Registers the writeback triple (dest_reg_index/value/write_valid_memwb_p1) that returns to the register file write port.
- Raises mem_stall_p1 so upstream holds the ixmem bundle while a multi-cycle access is in flight.

Parameters:
TIMEOUT_CYCLES, 64, cycles an access may wait in REQ plus RESP before it is aborted with an error (minimum 2).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dest_reg_value_ixmem_p1  in  16  ALU result: ST/STU update value, or non-memory writeback value
dest_reg_index_ixmem_p1  in  3  destination register index
dest_reg_write_valid_ixmem_p1  in  1  instruction writes a register
mem_addr_ixmem_p1  in  16  effective byte address
ldst_valid_ixmem_p1  in  1  memory operation present
store_valid_ixmem_p1  in  2  00 LD, 01 ST, 11 STU, 10 treated as ST
mem_data_in_ixmem_p1  in  16  store data
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  1 = write
dmem_req_addr  out  16  word-aligned address
dmem_req_wdata  out  16  write data
dmem_rsp_valid  in  1  load data valid
dmem_rsp_rdata  in  16  load data
mem_stall_p1  out  1  hold ixmem inputs stable this cycle
dest_reg_index_memwb_p1  out  3  writeback index
dest_reg_value_memwb_p1  out  16  writeback value
dest_reg_write_valid_memwb_p1  out  1  writeback enable
mem_err_memwb_p1  out  1  one-cycle pulse: unaligned access or timeout

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs go to 0; dmem_req_valid, dmem_req_we and mem_stall_p1 go low immediately.
  - An op in flight is dropped with no writeback and no error.
  - dmem_rsp_valid arriving after reset is ignored.
- States: IDLE, REQ, RESP.
- IDLE, ldst_valid=0:
  - Register the ixmem index, value and write_valid into the memwb outputs. Latency is 1 cycle.
  - mem_stall_p1=0.
- IDLE, ldst_valid=1, mem_addr[0]=1 (unaligned):
  - No request is issued and mem_stall_p1=0.
  - Next cycle: mem_err_memwb_p1=1 and write_valid_memwb=0.
- IDLE, ldst_valid=1, aligned:
  - Capture addr, wdata, op, index, value and write_valid; clear the counter; go to REQ.
  - mem_stall_p1=1 this cycle; memwb write_valid<=0 (bubble).
- REQ:
  - dmem_req_valid=1, driven from captured registers only.
  - we=1 for ST/STU, 0 for LD.
  - Request accepted when req_valid & req_ready in the same cycle.
  - Store accepted: go to IDLE, mem_stall_p1=0 that cycle. Next cycle memwb gets the captured index and value, with write_valid set to the captured flag (STU writes the update value; ST normally has flag 0).
  - Load accepted: go to RESP, mem_stall_p1=1.
  - dmem_rsp_valid is ignored in REQ.
- RESP:
  - dmem_req_valid=0.
  - On dmem_rsp_valid: mem_stall_p1=0 that cycle and go to IDLE. Next cycle memwb value=rdata, index=captured, write_valid=captured flag.
  - Otherwise mem_stall_p1=1.
- Completion cycle: mem_stall_p1=0, upstream advances, and the held bundle is consumed exactly once. Back-to-back memory ops are allowed; the next op launches from IDLE the following cycle.
- Timeout:
  - The counter increments in every REQ/RESP cycle without completion.
  - When the count reaches TIMEOUT_CYCLES-1 with no completion in that cycle, go to IDLE and drop mem_stall_p1 and dmem_req_valid.
  - Next cycle: mem_err_memwb_p1=1, write_valid_memwb=0.
  - A completion in the same cycle as the timeout wins, with no error.
- mem_err_memwb_p1 is 0 in every cycle except the error pulse.
- dmem_req_addr, dmem_req_wdata and dmem_req_we stay stable while req_valid=1 and ready=0.

Test Plan:
- Non-memory op, idx=3, value=0x1234, wv=1, ldst=0 -> next cycle memwb idx=3, value=0x1234, wv=1; stall never asserted.
- LD addr=0x0040, ready=1 on first REQ cycle, rsp 2 cycles later with rdata=0xBEEF, idx=5 -> stall high 4 cycles, one request, memwb value=0xBEEF, wv=1.
- STU addr=0x0102, wdata=0x00AA, value=0x0102, idx=2, ready delayed 3 cycles -> addr/wdata/we=1 held stable, then memwb idx=2, value=0x0102, wv=1; ST with wv=0 -> no writeback.
- LD addr=0x0013 -> no dmem_req_valid, no stall, mem_err pulse 1 cycle, wv=0.
- TIMEOUT_CYCLES=4, ready never asserted -> REQ lasts 4 cycles, then req_valid and stall drop, err pulse, wv=0; next non-memory op proceeds normally.
- Reset asserted in RESP, then rsp_valid arrives after reset release -> req_valid/stall low at once, state IDLE, response ignored, no writeback or error.
